// File: rtl/labyrinth_pkg.sv
// Shared types for the maze solver back end: node indices, predecessor
// memory words and the path tracer state encoding.
package labyrinth_pkg;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;
    localparam int NODE_W = 8;

    typedef logic [NODE_W-1:0] node_t;

    typedef struct packed {
        logic  has_pred;
        node_t pred;
    } pred_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_FINISH,
        ST_ERR
    } tracer_state_e;

endpackage

// File: rtl/path_lifo.sv
// Register-based LIFO holding the hops of the path being traced.
// Push and pop are mutually exclusive; flush empties it in one cycle.
module path_lifo #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign wr_idx = count_q[AW-1:0];
    assign rd_idx = AW'(count_q - CW'(1));

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push) begin
            count_d = count_q + CW'(1);
        end else if (pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_idx] <= din;
        end
    end

    assign top   = (count_q != '0) ? mem_q[rd_idx] : '0;
    assign count = count_q;

endmodule

// File: rtl/path_tracer.sv
// Walks the predecessor memory from target back to source, then streams the
// path source-first over valid/ready. Flags unreachable targets and cycles.
module path_tracer #(
    parameter int GRID_W    = labyrinth_pkg::GRID_W,
    parameter int GRID_H    = labyrinth_pkg::GRID_H,
    parameter int NODE_W    = labyrinth_pkg::NODE_W,
    parameter int MAX_NODES = GRID_W * GRID_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NODE_W-1:0] src_node,
    input  logic [NODE_W-1:0] dst_node,
    output logic [NODE_W-1:0] pred_addr,
    output logic              pred_rd,
    input  logic [NODE_W:0]   pred_rdata,
    output logic [NODE_W-1:0] path_node,
    output logic              path_valid,
    input  logic              path_ready,
    output logic              path_last,
    output logic              busy,
    output logic              done,
    output logic              error
);

    import labyrinth_pkg::*;

    localparam int HW = $clog2(MAX_NODES + 1);

    tracer_state_e     state_q, state_d;
    logic [NODE_W-1:0] src_q, src_d;
    logic [NODE_W-1:0] cur_q, cur_d;
    logic [HW-1:0]     hops_q, hops_d;
    logic              error_q, error_d;

    logic              lifo_push, lifo_pop, lifo_flush;
    logic [NODE_W-1:0] lifo_din, lifo_top;
    logic [HW-1:0]     lifo_count;

    logic              rd_has_pred;
    logic [NODE_W-1:0] rd_pred;

    assign rd_has_pred = pred_rdata[NODE_W];
    assign rd_pred     = pred_rdata[NODE_W-1:0];

    path_lifo #(
        .DEPTH (MAX_NODES),
        .WIDTH (NODE_W)
    ) u_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .flush (lifo_flush),
        .din   (lifo_din),
        .top   (lifo_top),
        .count (lifo_count)
    );

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cur_d      = cur_q;
        hops_d     = hops_q;
        error_d    = error_q;
        lifo_push  = 1'b0;
        lifo_pop   = 1'b0;
        lifo_flush = 1'b0;
        lifo_din   = '0;
        pred_rd    = 1'b0;
        pred_addr  = '0;
        path_valid = 1'b0;
        path_node  = '0;
        path_last  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d     = src_node;
                    cur_d     = dst_node;
                    lifo_push = 1'b1;
                    lifo_din  = dst_node;
                    hops_d    = HW'(1);
                    error_d   = 1'b0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Hop limit bounds the LIFO fill, so a cyclic chain cannot overflow it.
                if (cur_q == src_q) begin
                    state_d = ST_EMIT;
                end else if (hops_q == HW'(MAX_NODES)) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                pred_rd   = 1'b1;
                pred_addr = cur_q;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (!rd_has_pred) begin
                    state_d = ST_ERR;
                end else begin
                    lifo_push = 1'b1;
                    lifo_din  = rd_pred;
                    cur_d     = rd_pred;
                    hops_d    = hops_q + HW'(1);
                    state_d   = ST_CHECK;
                end
            end
            ST_EMIT: begin
                path_valid = 1'b1;
                path_node  = lifo_top;
                path_last  = (lifo_count == HW'(1));
                if (path_ready) begin
                    lifo_pop = 1'b1;
                    if (path_last) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                error_d    = 1'b1;
                lifo_flush = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            cur_q   <= '0;
            hops_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            cur_q   <= cur_d;
            hops_q  <= hops_d;
            error_q <= error_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign error = error_q;

endmodule

// File: doc/path_tracer.md
Name: path_tracer

Overview:
- Downstream of the Dijkstra datapath. Once the solver signals DONE, this block walks the predecessor memory from the target node back to the source node.
- Hops are pushed into an internal LIFO, so the path comes out in source-to-target order.
- Nodes are streamed over a valid/ready interface to the display/overlay logic.
- Also flags unreachable targets and corrupt (cyclic) predecessor chains.

Parameters:
- GRID_W, 16, maze width in cells
- GRID_H, 16, maze height in cells
- NODE_W, 8, node index width; must satisfy 2**NODE_W >= GRID_W*GRID_H
- MAX_NODES, GRID_W*GRID_H, LIFO depth and hop limit

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse (solver DONE rising edge); honoured only in IDLE
- src_node  in  NODE_W  source node index, sampled on accepted start
- dst_node  in  NODE_W  target node index, sampled on accepted start
- pred_addr  out  NODE_W  predecessor memory read address
- pred_rd  out  1  read strobe
- pred_rdata  in  NODE_W+1  read data, valid exactly 1 cycle after pred_rd; MSB = has_pred, LSBs = predecessor index
- path_node  out  NODE_W  streamed path node
- path_valid  out  1  path_node valid
- path_ready  in  1  consumer accepts when valid&&ready
- path_last  out  1  high with the final (target) node
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last beat is accepted
- error  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, LIFO empty, hop counter 0. Reset mid-trace aborts immediately; no beat completes.
- States: IDLE, CHECK, FETCH, WAIT, EMIT, FINISH, ERR.
- IDLE:
  - On start: latch src/dst, cur<=dst, push dst, hops<=1, clear error, go to CHECK.
  - start in any other state is ignored.
- CHECK:
  - cur==src_q -> EMIT.
  - else hops==MAX_NODES -> ERR (cycle guard).
  - else -> FETCH.
- FETCH: pred_rd=1, pred_addr=cur for exactly one cycle -> WAIT.
- WAIT: pred_rdata is valid in this cycle.
  - has_pred==0 -> ERR (unreachable).
  - else push pred index, cur<=pred index, hops++ -> CHECK.
  - Cost per hop: 3 cycles.
- EMIT: path_valid=1, path_node=LIFO top. Stream order is src..dst.
  - On valid&&ready: pop.
  - path_last=1 when LIFO occupancy==1.
  - After the last pop -> FINISH.
  - path_node/path_last must remain stable while valid&&!ready.
- FINISH: done=1 for one cycle -> IDLE.
- ERR: error<=1, LIFO flushed in one cycle, no beats emitted -> IDLE. done is not pulsed on error.
- Boundary cases:
  - src==dst: single beat, path_last=1.
  - Pushes never exceed MAX_NODES (guarded in CHECK); the LIFO never overflows and pop never occurs when empty.
  - Latency, start to first valid: 1 + 3*hops + 1 cycles.
- Widths: hop counter is $clog2(MAX_NODES+1) bits; LIFO pointer the same. No arithmetic on node indices.

Decomposition:
- labyrinth_pkg: NODE_W, GRID_W, GRID_H constants; node_t typedef; pred_word_t packed struct {has_pred, node_t pred}; tracer_state_e enum.
- Sub-module path_lifo:
  - Parameters DEPTH, WIDTH.
  - Ports push, pop, din, top, count, flush.
  - Single-cycle push/pop; simultaneous push+pop is unsupported; the FSM guarantees exclusivity.

Test Plan:
- Straight path: preds 3->2, 2->1, 1->0; src=0, dst=3, ready=1 -> beats 0,1,2,3; last on 3; done pulses once; 3 reads issued.
- src=dst=5 -> one beat, node 5, last=1, zero pred_rd; done one cycle after the accept.
- Unreachable: pred[7].has_pred=0, dst=7, src=0 -> error=1, no path_valid, done stays 0.
- Cycle: pred[4]=9, pred[9]=4, src=0, dst=4 -> error after MAX_NODES pushes; no valid beats.
- Backpressure: 4-node path with ready toggling 1,0,0,1,... -> node/last stable while stalled; order 0..3 intact.
- Reset asserted during EMIT after 2 beats -> valid drops asynchronously. A subsequent start with src=0, dst=3 produces a clean 4-beat stream.
